// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings, request-master FSM states and byte-lane helpers.
// Lane helpers assume little-endian lane ordering on a 32-bit data bus.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    function automatic logic [31:0] lane_replicate(input logic [31:0] wdata,
                                                   input logic [2:0]  size);
        logic [31:0] res;
        case (size)
            HSIZE_BYTE: res = {4{wdata[7:0]}};
            HSIZE_HALF: res = {2{wdata[15:0]}};
            default:    res = wdata;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] rdata,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [2:0]  size);
        logic [31:0] res;
        case (size)
            HSIZE_BYTE: begin
                case (addr_lo)
                    2'd0:    res = {24'b0, rdata[7:0]};
                    2'd1:    res = {24'b0, rdata[15:8]};
                    2'd2:    res = {24'b0, rdata[23:16]};
                    default: res = {24'b0, rdata[31:24]};
                endcase
            end
            HSIZE_HALF: res = addr_lo[1] ? {16'b0, rdata[31:16]} : {16'b0, rdata[15:0]};
            default:    res = rdata;
        endcase
        return res;
    endfunction

    // Requests that never reach the bus: wider than a word or not naturally aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic [2:0] size);
        return (size > HSIZE_WORD) ||
               ((size == HSIZE_HALF) && addr_lo[0]) ||
               ((size == HSIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/ahb3lite_req_master.sv
// Single-outstanding request/response to AHB3-Lite master.
// Each accepted request becomes one SINGLE transfer; bad requests are answered locally with an error.
module ahb3lite_req_master
    import ahb3lite_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        CLK,
    input  logic        RESETn,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    output logic        HSEL,
    output logic [31:0] HADDR,
    output logic [31:0] HWDATA,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HWRITE,
    output logic        HMASTLOCK,
    input  logic [31:0] HRDATA,
    input  logic        HRESP,
    input  logic        HREADY
);

    state_e      state_q;
    logic        ready_q;
    logic [1:0]  htrans_q;
    logic [31:0] haddr_q;
    logic [2:0]  hsize_q;
    logic        hwrite_q;
    logic [31:0] wdata_q;
    logic [31:0] hwdata_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    // ready_q is registered so it stays low until the first clock after reset release.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hsize_q     <= '0;
            hwrite_q    <= 1'b0;
            wdata_q     <= '0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && ready_q) begin
                        ready_q <= 1'b0;
                        if (is_misaligned(req_addr[1:0], req_size)) begin
                            state_q     <= ST_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q  <= ST_ADDR;
                            htrans_q <= HTRANS_NONSEQ;
                            haddr_q  <= req_addr;
                            hsize_q  <= req_size;
                            hwrite_q <= req_write;
                            wdata_q  <= req_wdata;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        state_q  <= ST_DATA;
                        htrans_q <= HTRANS_IDLE;
                        hwdata_q <= lane_replicate(wdata_q, hsize_q);
                    end
                end
                ST_DATA: begin
                    // HRESP with HREADY low is the first error cycle; wait for the second.
                    if (HREADY) begin
                        state_q     <= ST_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= HRESP;
                        rsp_rdata_q <= hwrite_q ? 32'b0 : lane_extract(HRDATA, haddr_q[1:0], hsize_q);
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    assign HSEL      = 1'b1;
    assign HADDR     = haddr_q;
    assign HWDATA    = hwdata_q;
    assign HTRANS    = htrans_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HWRITE    = hwrite_q;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb3lite_req_master.sv
// Bench for ahb3lite_req_master: directed vector table, reset corner cases and
// randomized transfers checked against a cycle-timeline reference model.
module tb_ahb3lite_req_master;
    import ahb3lite_pkg::*;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_size = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic        HMASTLOCK;
    logic [31:0] HRDATA = '0;
    logic        HRESP = 1'b0;
    logic        HREADY = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    ahb3lite_req_master #(.HPROT_VAL(4'b0011)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK),
        .HRDATA(HRDATA), .HRESP(HRESP), .HREADY(HREADY)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] hrdata;
        int          aw;        // address-phase wait states
        int          dw;        // data-phase wait states
        logic        err_wait;  // HRESP during data wait states
        logic        err_last;  // HRESP on the completing data cycle
        int          hold;      // cycles rsp_ready is held low
        logic        exp_bad;
        logic [31:0] exp_hwdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } txn_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic model_bad(input logic [31:0] addr, input logic [2:0] size);
        if (size > 3'd2) return 1'b1;
        if (size == 3'd1) return (addr % 2) != 0;
        if (size == 3'd2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_hwdata(input logic [31:0] w, input logic [2:0] size);
        if (size == 3'd0) return (w & 32'hFF) * 32'h01010101;
        if (size == 3'd1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] d, input logic [31:0] addr,
                                                input logic [2:0] size);
        logic [31:0] sh;
        sh = d >> (8 * (addr % 4));
        if (size == 3'd0) return sh & 32'hFF;
        if (size == 3'd1) return sh & 32'hFFFF;
        return d;
    endfunction

    // Drives one request and walks the expected cycle timeline, checking the bus and response.
    task automatic run_txn(input txn_t t);
        int cyc_rsp;
        int last_addr;
        int last_data;
        logic is_addr;
        logic is_data;
        last_addr = 1 + t.aw;
        last_data = 2 + t.aw + t.dw;
        cyc_rsp   = t.exp_bad ? 1 : 3 + t.aw + t.dw;

        @(negedge CLK);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = t.write;
        req_addr  = t.addr;
        req_wdata = t.wdata;
        req_size  = t.size;
        HRDATA    = t.hrdata;
        HREADY    = 1'b1;
        HRESP     = 1'b0;

        for (int cyc = 1; cyc <= cyc_rsp; cyc++) begin
            @(negedge CLK);
            req_valid = 1'b0;
            is_addr = !t.exp_bad && (cyc <= last_addr);
            is_data = !t.exp_bad && (cyc > last_addr) && (cyc <= last_data);
            chk("htrans", 32'(HTRANS), 32'(is_addr ? HTRANS_NONSEQ : HTRANS_IDLE));
            chk("rsp_valid_timing", 32'(rsp_valid), 32'(cyc == cyc_rsp));
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (is_addr) begin
                chk("haddr", HADDR, t.addr);
                chk("hsize", 32'(HSIZE), 32'(t.size));
                chk("hwrite", 32'(HWRITE), 32'(t.write));
            end
            if (is_data && t.write) chk("hwdata", HWDATA, t.exp_hwdata);
            if (cyc == cyc_rsp) begin
                chk("rsp_rdata", rsp_rdata, t.exp_rdata);
                chk("rsp_err", 32'(rsp_err), 32'(t.exp_err));
            end
            HREADY    = is_addr ? (cyc == last_addr) : (is_data ? (cyc == last_data) : 1'b1);
            HRESP     = is_data ? ((cyc == last_data) ? t.err_last : t.err_wait) : 1'b0;
            rsp_ready = (cyc == cyc_rsp) && (t.hold == 0);
        end

        for (int k = 1; k <= t.hold; k++) begin
            @(negedge CLK);
            chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_hold_rdata", rsp_rdata, t.exp_rdata);
            chk("rsp_hold_err", 32'(rsp_err), 32'(t.exp_err));
            chk("rsp_hold_ready", 32'(req_ready), 32'd0);
            rsp_ready = (k == t.hold);
        end

        @(negedge CLK);
        chk("rsp_done_valid", 32'(rsp_valid), 32'd0);
        chk("back_to_idle", 32'(req_ready), 32'd1);
        rsp_ready = 1'b0;
    endtask

    txn_t vec [12];
    txn_t rt;

    initial begin
        // write addr wdata size hrdata aw dw ew el hold | bad hwdata rdata err
        vec[0]  = '{1'b1, 32'h20000010, 32'hDEADBEEF, 3'd2, 32'h0,        0, 0, 1'b0, 1'b0, 0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0};
        vec[1]  = '{1'b0, 32'h00000003, 32'h0,        3'd0, 32'hAB000000, 0, 3, 1'b0, 1'b0, 0, 1'b0, 32'h0,        32'h000000AB, 1'b0};
        vec[2]  = '{1'b0, 32'h00000100, 32'h0,        3'd2, 32'h12345678, 0, 1, 1'b1, 1'b1, 1, 1'b0, 32'h0,        32'h12345678, 1'b1};
        vec[3]  = '{1'b1, 32'h00000001, 32'h0000BEEF, 3'd1, 32'h0,        0, 0, 1'b0, 1'b0, 0, 1'b1, 32'h0,        32'h0,        1'b1};
        vec[4]  = '{1'b0, 32'h00000040, 32'h0,        3'd2, 32'hCAFEF00D, 0, 0, 1'b0, 1'b0, 5, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0};
        vec[5]  = '{1'b1, 32'h00000002, 32'h11223344, 3'd0, 32'h0,        1, 0, 1'b0, 1'b0, 0, 1'b0, 32'h44444444, 32'h0,        1'b0};
        vec[6]  = '{1'b1, 32'h00000002, 32'hAAAA5678, 3'd1, 32'h0,        0, 2, 1'b0, 1'b0, 2, 1'b0, 32'h56785678, 32'h0,        1'b0};
        vec[7]  = '{1'b0, 32'h00000002, 32'h0,        3'd1, 32'hBEEF1234, 0, 0, 1'b0, 1'b0, 0, 1'b0, 32'h0,        32'h0000BEEF, 1'b0};
        vec[8]  = '{1'b0, 32'h00000001, 32'h0,        3'd0, 32'h0000C300, 2, 0, 1'b0, 1'b0, 1, 1'b0, 32'h0,        32'h000000C3, 1'b0};
        vec[9]  = '{1'b0, 32'h00000000, 32'h0,        3'd3, 32'hFFFFFFFF, 0, 0, 1'b0, 1'b0, 0, 1'b1, 32'h0,        32'h0,        1'b1};
        vec[10] = '{1'b0, 32'h00000002, 32'h0,        3'd2, 32'h0,        0, 0, 1'b0, 1'b0, 0, 1'b1, 32'h0,        32'h0,        1'b1};
        vec[11] = '{1'b1, 32'h00000008, 32'h01020304, 3'd2, 32'h0,        0, 0, 1'b0, 1'b1, 0, 1'b0, 32'h01020304, 32'h0,        1'b1};

        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_hsize", 32'(HSIZE), 32'd0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("hsel", 32'(HSEL), 32'd1);
        chk("hburst", 32'(HBURST), 32'(HBURST_SINGLE));
        chk("hprot", 32'(HPROT), 32'h3);
        chk("hmastlock", 32'(HMASTLOCK), 32'd0);
        repeat (2) @(negedge CLK);
        chk("rst_held_ready", 32'(req_ready), 32'd0);
        RESETn = 1'b1;
        @(negedge CLK);
        chk("ready_after_release", 32'(req_ready), 32'd1);

        foreach (vec[i]) run_txn(vec[i]);

        // Reset pulse in the address phase with the slave stalling.
        @(negedge CLK);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h00000080; req_size = 3'd2;
        HREADY = 1'b1;
        @(negedge CLK);
        req_valid = 1'b0;
        chk("abort_nonseq", 32'(HTRANS), 32'(HTRANS_NONSEQ));
        HREADY = 1'b0;
        #2 RESETn = 1'b0;
        #1;
        chk("abort_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        chk("abort_haddr", HADDR, 32'h0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        HREADY = 1'b1;
        @(negedge CLK);
        chk("abort_rsp_none", 32'(rsp_valid), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        rt = '{1'b0, 32'h00000200, 32'h0, 3'd2, 32'h600DF00D, 0, 0, 1'b0, 1'b0, 0, 1'b0, 32'h0, 32'h600DF00D, 1'b0};
        run_txn(rt);

        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 9);
            rt.write    = 1'($urandom_range(0, 1));
            rt.addr     = $urandom;
            rt.wdata    = $urandom;
            rt.size     = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
            rt.hrdata   = $urandom;
            rt.aw       = $urandom_range(0, 2);
            rt.dw       = $urandom_range(0, 3);
            rt.err_last = ($urandom_range(0, 3) == 0);
            rt.err_wait = rt.err_last && (rt.dw > 0);
            rt.hold     = $urandom_range(0, 2);
            rt.exp_bad    = model_bad(rt.addr, rt.size);
            rt.exp_hwdata = model_hwdata(rt.wdata, rt.size);
            rt.exp_rdata  = (rt.exp_bad || rt.write) ? 32'h0 : model_rdata(rt.hrdata, rt.addr, rt.size);
            rt.exp_err    = rt.exp_bad || rt.err_last;
            run_txn(rt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
